// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the ID-stage branch resolution controller.
// Branch command encodings match the condition checker; BC_* encode the controller FSM.
package branch_ctrl_pkg;

  localparam int WORD_LEN = 32;

  typedef enum logic [1:0] {
    COND_JUMP = 2'b00,
    COND_BEZ  = 2'b01,
    COND_BEQ  = 2'b10,
    COND_NONE = 2'b11
  } condCmd_e;

  typedef enum logic [1:0] {
    BC_IDLE  = 2'b00,
    BC_WAIT  = 2'b01,
    BC_FLUSH = 2'b10
  } bcState_e;

  function automatic logic [1:0] maxDepth(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Bundle between the ID/hazard/PC-mux side (master) and the branch controller (slave).
// Carries branch request, hazard sources, redirect/flush/stall outputs and statistics.
interface branch_ctrl_if #(
  parameter int CNT_W = 16
);
  import branch_ctrl_pkg::*;

  logic                brValid;
  logic [1:0]          brComm;
  logic [WORD_LEN-1:0] brTarget;
  logic [4:0]          src1;
  logic [4:0]          src2;
  logic                exWbEn;
  logic                exMemRead;
  logic [4:0]          exDest;
  logic                memMemRead;
  logic [4:0]          memDest;
  logic                brCond;

  logic                stall;
  logic                flush;
  logic                pcSel;
  logic [WORD_LEN-1:0] pcTarget;
  logic [CNT_W-1:0]    statBr;
  logic [CNT_W-1:0]    statTaken;
  logic [CNT_W-1:0]    statStall;

  modport master (
    output brValid, brComm, brTarget, src1, src2, exWbEn, exMemRead, exDest,
           memMemRead, memDest, brCond,
    input  stall, flush, pcSel, pcTarget, statBr, statTaken, statStall
  );

  modport slave (
    input  brValid, brComm, brTarget, src1, src2, exWbEn, exMemRead, exDest,
           memMemRead, memDest, brCond,
    output stall, flush, pcSel, pcTarget, statBr, statTaken, statStall
  );

endinterface

// File: rtl/branch_hazard_depth.sv
// Combinational stall depth for a branch in ID: how many cycles until its operands
// can be forwarded (EX load = 2, EX ALU result or MEM load = 1, register 0 never).
module branch_hazard_depth
  import branch_ctrl_pkg::*;
(
  input  logic [1:0] brComm,
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic       exWbEn,
  input  logic       exMemRead,
  input  logic [4:0] exDest,
  input  logic       memMemRead,
  input  logic [4:0] memDest,
  output logic [1:0] depth
);

  function automatic logic [1:0] srcDepth(
    input logic [4:0] src,
    input logic       exWb,
    input logic       exLoad,
    input logic [4:0] exRd,
    input logic       memLoad,
    input logic [4:0] memRd
  );
    logic [1:0] d;
    d = 2'd0;
    if (src != 5'd0) begin
      if (memLoad && (memRd == src)) d = 2'd1;
      if (exWb && (exRd == src))     d = maxDepth(d, exLoad ? 2'd2 : 2'd1);
    end
    return d;
  endfunction

  logic       checkSrc1;
  logic       checkSrc2;
  logic [1:0] depth1;
  logic [1:0] depth2;

  // JUMP reads no registers; BEZ reads only src1; BEQ reads both.
  always_comb begin
    checkSrc1 = (brComm == COND_BEZ) || (brComm == COND_BEQ);
    checkSrc2 = (brComm == COND_BEQ);
    depth1    = 2'd0;
    depth2    = 2'd0;
    if (checkSrc1) depth1 = srcDepth(src1, exWbEn, exMemRead, exDest, memMemRead, memDest);
    if (checkSrc2) depth2 = srcDepth(src2, exWbEn, exMemRead, exDest, memMemRead, memDest);
    depth = maxDepth(depth1, depth2);
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution controller: stalls on operand hazards, then redirects and flushes.
// Define BRANCH_STATS_EN to build saturating branch/taken/stall counters; otherwise stats read 0.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          rst,
  branch_ctrl_if.slave bus
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_DEPTH - 1);

  bcState_e   state;
  bcState_e   stateNext;
  logic [1:0] wcnt;
  logic [1:0] wcntNext;
  logic [1:0] fcnt;
  logic [1:0] fcntNext;
  logic [1:0] depth;
  logic       resolve;
  logic       stall;
  logic       flush;
  logic       pcSel;

  branch_hazard_depth hazardDepth (
    .brComm     (bus.brComm),
    .src1       (bus.src1),
    .src2       (bus.src2),
    .exWbEn     (bus.exWbEn),
    .exMemRead  (bus.exMemRead),
    .exDest     (bus.exDest),
    .memMemRead (bus.memMemRead),
    .memDest    (bus.memDest),
    .depth      (depth)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BC_IDLE;
      wcnt  <= 2'd0;
      fcnt  <= 2'd0;
    end else begin
      state <= stateNext;
      wcnt  <= wcntNext;
      fcnt  <= fcntNext;
    end
  end

  // Hazards are judged only on entry; once in WAIT the countdown alone decides resolve.
  always_comb begin
    stateNext = state;
    wcntNext  = wcnt;
    fcntNext  = fcnt;
    stall     = 1'b0;
    flush     = 1'b0;
    pcSel     = 1'b0;
    resolve   = 1'b0;

    case (state)
      BC_IDLE: begin
        if (bus.brValid && (bus.brComm != COND_NONE)) begin
          if (depth != 2'd0) begin
            stall     = 1'b1;
            wcntNext  = depth - 2'd1;
            stateNext = BC_WAIT;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      BC_WAIT: begin
        if (wcnt != 2'd0) begin
          stall    = 1'b1;
          wcntNext = wcnt - 2'd1;
        end else begin
          resolve = 1'b1;
        end
      end
      BC_FLUSH: begin
        flush = 1'b1;
        if (fcnt <= 2'd1) begin
          fcntNext  = 2'd0;
          stateNext = BC_IDLE;
        end else begin
          fcntNext = fcnt - 2'd1;
        end
      end
      default: stateNext = BC_IDLE;
    endcase

    // The resolve cycle carries the first flush, so FLUSH covers the remaining DEPTH-1 cycles.
    if (resolve) begin
      stateNext = BC_IDLE;
      if (bus.brCond) begin
        pcSel = 1'b1;
        flush = 1'b1;
        if (FLUSH_DEPTH > 1) begin
          stateNext = BC_FLUSH;
          fcntNext  = FLUSH_LOAD;
        end
      end
    end
  end

  assign bus.stall    = stall;
  assign bus.flush    = flush;
  assign bus.pcSel    = pcSel;
  assign bus.pcTarget = pcSel ? bus.brTarget : '0;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] statBrQ;
  logic [CNT_W-1:0] statTakenQ;
  logic [CNT_W-1:0] statStallQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      statBrQ    <= '0;
      statTakenQ <= '0;
      statStallQ <= '0;
    end else begin
      if (resolve && !(&statBrQ))    statBrQ    <= statBrQ + 1'b1;
      if (pcSel && !(&statTakenQ))   statTakenQ <= statTakenQ + 1'b1;
      if (stall && !(&statStallQ))   statStallQ <= statStallQ + 1'b1;
    end
  end

  assign bus.statBr    = statBrQ;
  assign bus.statTaken = statTakenQ;
  assign bus.statStall = statStallQ;
`else
  assign bus.statBr    = '0;
  assign bus.statTaken = '0;
  assign bus.statStall = '0;
`endif

endmodule
